// File: rtl/trans_mem_uart_tx.sv
// Drains transmit memories 1 then 2 through their read ports and serialises
// each byte as UART 8N1 (LSB first); pulses done after the last stop bit.
module trans_mem_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned WORDS        = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] Trans_Mem1_ADDRB,
    output logic       Trans_Mem1_RENB,
    input  logic [7:0] Trans_Mem1_DOUTB,
    output logic [3:0] Trans_Mem2_ADDRB,
    output logic       Trans_Mem2_RENB,
    input  logic [7:0] Trans_Mem2_DOUTB,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] tx_state
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        WORD_LAST = 4'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q,    state_d;
    logic                mem_sel_q,  mem_sel_d;
    logic [3:0]          word_idx_q, word_idx_d;
    logic [7:0]          shift_q,    shift_d;
    logic [2:0]          bit_idx_q,  bit_idx_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [3:0]          addr1_q,    addr1_d;
    logic [3:0]          addr2_q,    addr2_d;
    logic                ren1_q,     ren1_d;
    logic                ren2_q,     ren2_d;
    logic                tx_q,       tx_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                baud_end;

    // Outputs are registered from the next-state values so they line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        mem_sel_d  = mem_sel_q;
        word_idx_d = word_idx_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        addr1_d    = addr1_q;
        addr2_d    = addr2_q;
        baud_end   = (baud_cnt_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_sel_d  = 1'b0;
                    word_idx_d = 4'd0;
                    state_d    = S_READ;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                shift_d    = mem_sel_q ? Trans_Mem2_DOUTB : Trans_Mem1_DOUTB;
                baud_cnt_d = '0;
                bit_idx_d  = 3'd0;
                state_d    = S_START;
            end
            S_START: begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                if (baud_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                if (baud_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (word_idx_q < WORD_LAST) begin
                        word_idx_d = word_idx_q + 4'd1;
                        state_d    = S_READ;
                    end else if (!mem_sel_q) begin
                        mem_sel_d  = 1'b1;
                        word_idx_d = 4'd0;
                        state_d    = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ren1_d = (state_d == S_READ) && !mem_sel_d;
        ren2_d = (state_d == S_READ) &&  mem_sel_d;
        if (ren1_d) addr1_d = word_idx_d;
        if (ren2_d) addr2_d = word_idx_d;

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mem_sel_q  <= 1'b0;
            word_idx_q <= 4'd0;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= '0;
            addr1_q    <= 4'd0;
            addr2_q    <= 4'd0;
            ren1_q     <= 1'b0;
            ren2_q     <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_sel_q  <= mem_sel_d;
            word_idx_q <= word_idx_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            ren1_q     <= ren1_d;
            ren2_q     <= ren2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Trans_Mem1_ADDRB = addr1_q;
    assign Trans_Mem1_RENB  = ren1_q;
    assign Trans_Mem2_ADDRB = addr2_q;
    assign Trans_Mem2_RENB  = ren2_q;
    assign tx               = tx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign tx_state         = state_q;

endmodule

// File: tb/tb_trans_mem_uart_tx.sv
// Directed bench for trans_mem_uart_tx: memory models, a UART receiver and
// a read-port monitor feed hand-computed expectations.
module tb_trans_mem_uart_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned NW  = 16;

    logic       clock, reset, start;
    logic [3:0] addr1, addr2;
    logic       ren1, ren2;
    logic [7:0] dout1, dout2;
    logic       tx, busy, done;
    logic [2:0] tx_state;

    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];

    logic [7:0] rx_q [$];
    logic [3:0] a1_q [$];
    logic [3:0] a2_q [$];
    int         ovl;

    int n_cmp, n_err;

    trans_mem_uart_tx #(.CLKS_PER_BIT(CPB), .WORDS(NW)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .Trans_Mem1_ADDRB (addr1),
        .Trans_Mem1_RENB  (ren1),
        .Trans_Mem1_DOUTB (dout1),
        .Trans_Mem2_ADDRB (addr2),
        .Trans_Mem2_RENB  (ren2),
        .Trans_Mem2_DOUTB (dout2),
        .tx               (tx),
        .busy             (busy),
        .done             (done),
        .tx_state         (tx_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clock) begin
        if (ren1) dout1 <= mem1[addr1];
        if (ren2) dout2 <= mem2[addr2];
    end

    // Read-port monitor.
    initial ovl = 0;
    always @(negedge clock) begin
        if (ren1 === 1'b1 && ren2 === 1'b1) ovl++;
        if (ren1 === 1'b1) a1_q.push_back(addr1);
        if (ren2 === 1'b1) a2_q.push_back(addr2);
    end

    // UART receiver: first low sample is the first start-bit cycle; sample mid-bit.
    always begin
        logic [7:0] b;
        @(negedge clock);
        if (tx === 1'b0 && reset === 1'b0) begin
            repeat (CPB / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clock);
            rx_q.push_back(b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge; returns in cycle 1 (the READ cycle).
    task automatic kick();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    logic [9:0] frame_a5;
    int qb, b1, b2, ob, done_n, done_at;

    initial begin
        n_cmp = 0;
        n_err = 0;
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 8'(i);
            mem2[i] = 8'(8'h80 + i);
        end
        mem1[0] = 8'hA5;

        // Reset held with start asserted.
        start = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_tx",    32'(tx), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_ren1",  32'(ren1), 32'd0);
        check("rst_ren2",  32'(ren2), 32'd0);
        check("rst_addr1", 32'(addr1), 32'd0);
        check("rst_addr2", 32'(addr2), 32'd0);
        check("rst_state", 32'(tx_state), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_state", 32'(tx_state), 32'd0);

        // Single frame of 0xA5: start, 10100101 LSB first, stop.
        frame_a5 = 10'b11_0100_1010;
        qb = rx_q.size();
        kick();
        check("f_ren1",  32'(ren1), 32'd1);
        check("f_addr1", 32'(addr1), 32'd0);
        check("f_ren2",  32'(ren2), 32'd0);
        check("f_read",  32'(tx_state), 32'd1);
        check("f_busy",  32'(busy), 32'd1);
        @(negedge clock);
        check("f_load",  32'(tx_state), 32'd2);
        check("f_ltx",   32'(tx), 32'd1);
        for (int k = 3; k <= 42; k++) begin
            @(negedge clock);
            check($sformatf("f_tx_c%0d", k), 32'(tx), 32'(frame_a5[(k - 3) / CPB]));
        end
        @(negedge clock);
        check("f_next_ren1",  32'(ren1), 32'd1);
        check("f_next_addr1", 32'(addr1), 32'd1);
        check("f_rx_cnt",     32'(rx_q.size() - qb), 32'd1);
        if (rx_q.size() > qb) check("f_rx_byte", 32'(rx_q[qb]), 32'hA5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("f_abort_state", 32'(tx_state), 32'd0);
        check("f_abort_ren1",  32'(ren1), 32'd0);
        repeat (10) @(negedge clock);

        // Full drain, with start pulses at cycles 10, 500 and the DONE cycle.
        mem1[0] = 8'h00;
        qb = rx_q.size();
        b1 = a1_q.size();
        b2 = a2_q.size();
        ob = ovl;
        done_n = 0;
        done_at = 0;
        kick();
        for (int k = 1; k <= 1400; k++) begin
            if (k > 1) @(negedge clock);
            start = (k == 10 || k == 500 || k == 1345);
            if (done === 1'b1) begin
                done_n++;
                done_at = k;
            end
            if (k == 1345) check("d_busy_in_done", 32'(busy), 32'd1);
            if (k == 1346) begin
                check("d_busy_after", 32'(busy), 32'd0);
                check("d_state_after", 32'(tx_state), 32'd0);
            end
        end
        start = 1'b0;
        check("d_done_count", 32'(done_n), 32'd1);
        check("d_done_cycle", 32'(done_at), 32'd1345);
        check("d_busy_end",   32'(busy), 32'd0);
        check("d_rx_count",   32'(rx_q.size() - qb), 32'd32);
        for (int i = 0; i < 32; i++) begin
            if (qb + i < rx_q.size())
                check($sformatf("d_byte%0d", i), 32'(rx_q[qb + i]),
                      (i < 16) ? 32'(i) : 32'(8'h80 + (i - 16)));
        end
        check("d_ren1_pulses", 32'(a1_q.size() - b1), 32'd16);
        check("d_ren2_pulses", 32'(a2_q.size() - b2), 32'd16);
        check("d_overlap",     32'(ovl - ob), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (b1 + i < a1_q.size()) check($sformatf("d_a1_%0d", i), 32'(a1_q[b1 + i]), 32'(i));
            if (b2 + i < a2_q.size()) check($sformatf("d_a2_%0d", i), 32'(a2_q[b2 + i]), 32'(i));
        end

        // Reset during DATA bit 3 of word 5 (cycles 229..232), then restart.
        kick();
        for (int k = 2; k <= 230; k++) begin
            @(negedge clock);
            if (k == 229) check("m_in_data", 32'(tx_state), 32'd4);
            if (k == 230) reset = 1'b1;
        end
        @(negedge clock);
        reset = 1'b0;
        check("m_tx",    32'(tx), 32'd1);
        check("m_state", 32'(tx_state), 32'd0);
        check("m_busy",  32'(busy), 32'd0);
        check("m_addr1", 32'(addr1), 32'd0);
        repeat (60) @(negedge clock);
        check("m_idle",  32'(tx_state), 32'd0);
        b1 = a1_q.size();
        b2 = a2_q.size();
        kick();
        check("m_re_ren1",  32'(ren1), 32'd1);
        check("m_re_addr1", 32'(addr1), 32'd0);
        done_at = 0;
        for (int k = 2; k <= 1500; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
        end
        check("m_re_done_cycle", 32'(done_at), 32'd1345);
        check("m_re_ren1_pulses", 32'(a1_q.size() - b1), 32'd16);
        check("m_re_ren2_pulses", 32'(a2_q.size() - b2), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
